// File: rtl/bicubic_stage2_operand_issuer.sv
// bicubic_stage2_operand_issuer: holds one 4-tap column and issues it once per phase with its weight codes
module bicubic_stage2_operand_issuer #(
  parameter int INTER_PRODUCT_WIDTH = 24,
  parameter int SCALE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INTER_PRODUCT_WIDTH-1:0] in_pixel_1,
  input  logic [INTER_PRODUCT_WIDTH-1:0] in_pixel_2,
  input  logic [INTER_PRODUCT_WIDTH-1:0] in_pixel_3,
  input  logic [INTER_PRODUCT_WIDTH-1:0] in_pixel_4,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INTER_PRODUCT_WIDTH-1:0] pixel_1,
  output logic [INTER_PRODUCT_WIDTH-1:0] pixel_2,
  output logic [INTER_PRODUCT_WIDTH-1:0] pixel_3,
  output logic [INTER_PRODUCT_WIDTH-1:0] pixel_4,
  output logic [2:0]                     weight_1,
  output logic [2:0]                     weight_2,
  output logic [2:0]                     weight_3,
  output logic [2:0]                     weight_4,
  output logic [1:0]                     out_phase,
  output logic                           out_last
);
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic [1:0] LAST_P = 2'(SCALE - 1);
  state_t     state;
  logic [1:0] p;
  logic       held_last;
  logic       accept;
  logic [11:0] w;
  assign in_ready  = (state == IDLE) || (p == LAST_P && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ISSUE);
  assign out_phase = p;
  assign out_last  = held_last && (p == LAST_P);
  // Codes are packed tap1..tap4 from MSB; forced to zero whenever nothing is issued.
  always_comb begin
    w = !out_valid  ? 12'o0000 :
        p == 2'd0   ? 12'o0123 :
        p == 2'd1   ? 12'o4567 :
        p == 2'd2   ? 12'o7654 : 12'o3210;
  end
  assign {weight_1, weight_2, weight_3, weight_4} = w;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= 2'd0;
      held_last <= 1'b0;
      pixel_1   <= '0;
      pixel_2   <= '0;
      pixel_3   <= '0;
      pixel_4   <= '0;
    end else if (accept) begin
      state     <= ISSUE;
      p         <= 2'd0;
      held_last <= in_last;
      pixel_1   <= in_pixel_1;
      pixel_2   <= in_pixel_2;
      pixel_3   <= in_pixel_3;
      pixel_4   <= in_pixel_4;
    end else if (out_valid && out_ready) begin
      state <= (p == LAST_P) ? IDLE : ISSUE;
      p     <= (p == LAST_P) ? 2'd0 : p + 2'd1;
    end
  end
endmodule
